// File: rtl/hex_ctrl_pkg.sv
// Shared types for the seven-segment display control path: digit/display words and the arbiter state encoding.
// Pure declarations: no logic, no latency, no flow control.
package hex_ctrl_pkg;

  localparam int N_DIGITS = 8;

  typedef logic [3:0] digit_t;
  typedef digit_t [N_DIGITS-1:0] disp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/hex_disp_arbiter_rr_pick.sv
// Round-robin first-set search: lowest set req at or above rr_ptr, wrapping to 0.
// Combinational (zero latency); no flow control.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [IW-1:0] pick,
  output logic          any
);

  logic [IW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set bit is the last written.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IW'((int'(rr_ptr) + i) % N);
      if (req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex_disp_arbiter.sv
// Shares one 8-digit display among N_REQ clients: round-robin grant, time-slice preemption, 1-cycle blank gap, blink.
// Grant 1 cycle after req; display outputs registered 1 cycle after the owner's inputs; no backpressure (level req/grant).
module hex_disp_arbiter
  import hex_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter logic [31:0] TIMESLICE = 32'd50_000_000,
  parameter logic [31:0] BLINK_DIV = 32'd25_000_000,
  localparam int unsigned IW       = $clog2(N_REQ)
) (
  input  logic                                     clk,
  input  logic                                     clr,
  input  logic [N_REQ-1:0]                         req,
  output logic [N_REQ-1:0]                         grant,
  input  logic [N_REQ-1:0][N_DIGITS-1:0]           req_en,
  input  logic [N_REQ-1:0][N_DIGITS-1:0][3:0]      req_display,
  input  logic [N_REQ-1:0][N_DIGITS-1:0]           req_dots,
  input  logic [N_REQ-1:0][N_DIGITS-1:0]           req_blink,
  output logic [N_DIGITS-1:0]                      en,
  output logic [N_DIGITS-1:0][3:0]                 display,
  output logic [N_DIGITS-1:0]                      dots,
  output logic [IW-1:0]                            owner_id,
  output logic                                     owner_valid
);

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  arb_state_t            state_q;
  logic [N_REQ-1:0]      grant_q;
  logic [IW-1:0]         owner_id_q;
  logic                  owner_valid_q;
  logic [N_DIGITS-1:0]   en_q;
  logic [N_DIGITS-1:0]   dots_q;
  disp_t                 display_q;
  logic [IW-1:0]         rr_ptr_q;
  logic [31:0]           slice_cnt_q;

  logic [31:0]           blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic                  blink_wrap;

  logic [IW-1:0]         pick;
  logic                  any_req;
  logic [IW-1:0]         next_ptr;
  logic [N_REQ-1:0]      owner_oh;
  logic                  owner_req;
  logic                  others_req;
  logic                  slice_end;
  logic [N_DIGITS-1:0]   owner_en;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .pick   (pick),
    .any    (any_req)
  );

  always_comb begin
    next_ptr   = (pick == IW'(N_REQ - 1)) ? '0 : pick + IW'(1);
    owner_oh   = ONE << owner_id_q;
    owner_req  = req[owner_id_q];
    others_req = |(req & ~owner_oh);
    slice_end  = (TIMESLICE != 32'd0) && (slice_cnt_q == TIMESLICE - 32'd1);
    owner_en   = req_en[owner_id_q] & ~(req_blink[owner_id_q] & {N_DIGITS{blink_phase_q}});
  end

  // Blink timebase runs regardless of ownership so all clients see a common phase.
  always_comb begin
    blink_wrap    = (blink_cnt_q == BLINK_DIV - 32'd1);
    blink_cnt_d   = blink_wrap ? 32'd0 : blink_cnt_q + 32'd1;
    blink_phase_d = blink_phase_q ^ blink_wrap;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      blink_cnt_q   <= 32'd0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      owner_id_q    <= '0;
      owner_valid_q <= 1'b0;
      en_q          <= '0;
      dots_q        <= '0;
      display_q     <= '0;
      rr_ptr_q      <= '0;
      slice_cnt_q   <= 32'd0;
    end else begin
      unique case (state_q)
        // GAP differs from IDLE only in having already blanked; both arbitrate on the current req.
        IDLE, GAP: begin
          en_q          <= '0;
          dots_q        <= '0;
          grant_q       <= '0;
          owner_valid_q <= 1'b0;
          if (any_req) begin
            state_q       <= OWN;
            grant_q       <= ONE << pick;
            owner_id_q    <= pick;
            owner_valid_q <= 1'b1;
            rr_ptr_q      <= next_ptr;
            slice_cnt_q   <= 32'd0;
          end else begin
            state_q <= IDLE;
          end
        end
        OWN: begin
          if (!owner_req || (slice_end && others_req)) begin
            state_q       <= GAP;
            grant_q       <= '0;
            owner_valid_q <= 1'b0;
            en_q          <= '0;
            dots_q        <= '0;
          end else begin
            display_q <= req_display[owner_id_q];
            dots_q    <= req_dots[owner_id_q];
            en_q      <= owner_en;
            if (TIMESLICE != 32'd0 && !slice_end) begin
              slice_cnt_q <= slice_cnt_q + 32'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign owner_id    = owner_id_q;
  assign owner_valid = owner_valid_q;
  assign en          = en_q;
  assign display     = display_q;
  assign dots        = dots_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (clr)
    $onehot0(grant_q) && (owner_valid_q == (grant_q != '0)));

  // A new grant may only go to a client that was requesting when it was decided.
  a_grant_to_requester: assert property (@(posedge clk) disable iff (clr)
    (state_q != OWN) |=> ((grant_q & $past(req)) == grant_q));

endmodule

// File: doc/hex_disp_arbiter.md
Name: hex_disp_arbiter

Overview:
- Shares the 8-digit multiplexed seven-segment display between N_REQ independent clients (CPU MMIO, debug monitor, trap/status reporter, ...).
- Round-robin arbitration with request/grant handshake and time-slice preemption.
- One-cycle blanking gap on every ownership change.
- Per-digit blink generated here.
- Output drives the display scanner's en/display/dots inputs directly; the scanner is unchanged.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMESLICE, 32'd50_000_000, cycles an owner may hold the display while another client waits; 0 disables preemption.
- BLINK_DIV, 32'd25_000_000, cycles per blink half-period (≥1).

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous active-high reset
- req  in  N_REQ  per-client display request, level-held
- grant  out  N_REQ  one-hot ownership, registered
- req_en  in  N_REQ×8  per-client digit enables
- req_display  in  N_REQ×8×4  per-client hex nibbles, digit 0 = rightmost
- req_dots  in  N_REQ×8  per-client decimal points
- req_blink  in  N_REQ×8  per-client blink mask (1 = digit blinks)
- en  out  8  to scanner: digit enables
- display  out  8×4  to scanner: nibbles
- dots  out  8  to scanner: decimal points
- owner_id  out  $clog2(N_REQ)  index of current owner, valid only with owner_valid
- owner_valid  out  1  a client currently owns the display

Behaviour:
- One clock; reset is synchronous and active-high: clk, clr.
- clr has priority over everything, including mid-ownership and mid-gap.
- Reset values: state=IDLE, grant=0, owner_valid=0, owner_id=0, en=0, display=0, dots=0, rr_ptr=0, slice_cnt=0, blink_cnt=0, blink_phase=0.
- States: IDLE, OWN, GAP.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from rr_ptr with wrap (index rr_ptr included).
  - Next cycle: grant=onehot(pick), owner_id=pick, owner_valid=1, rr_ptr=pick+1 mod N_REQ, slice_cnt=0, go to OWN.
  - Grant latency from req is 1 cycle.
- OWN:
  - If req[owner]=0, go to GAP next cycle.
  - Else if TIMESLICE≠0, slice_cnt==TIMESLICE-1, and any other req bit is set, go to GAP (preemption).
  - Else slice_cnt increments and saturates at TIMESLICE-1. The owner keeps the display indefinitely when uncontested.
- GAP (exactly 1 cycle):
  - grant=0, owner_valid=0, en=0.
  - Next cycle, apply the IDLE pick rule to that cycle's req: pick → OWN, none → IDLE.
  - A preempted client still requesting re-enters arbitration at its rotated priority (lowest if rr_ptr moved past it).
- Outputs in OWN, registered, 1 cycle after the owner's inputs:
  - display=req_display[owner]
  - dots=req_dots[owner]
  - en=req_en[owner] & ~(req_blink[owner] & {8{blink_phase}})
- Outputs in IDLE and GAP: en=0, dots=0, display holds its last value.
- Blink counter:
  - Free-running, independent of state.
  - blink_cnt counts 0..BLINK_DIV-1. On wrap, blink_phase toggles.
  - Phase 0 = visible, phase 1 = blinking digits off.
- Simultaneous events:
  - Owner drops req on the same cycle the slice expires: treated as release. Same GAP path, no distinction.
  - Request arriving during GAP: eligible at GAP exit.
- Grant is never asserted for a client whose req was 0 in the deciding cycle.
- Grant is never more than one-hot.

Decomposition:
- Package hex_ctrl_pkg holds:
  - N_DIGITS=8
  - typedef digit_t = logic[3:0]
  - typedef disp_t = digit_t[N_DIGITS-1:0]
  - enum arb_state_t {IDLE, OWN, GAP}
- Sub-module rr_pick: combinational round-robin first-set search.
  - Inputs: req, rr_ptr.
  - Outputs: pick index, any.
  - Reusable by other arbiters.

Test Plan (N_REQ=4, TIMESLICE=8, BLINK_DIV=4):
- Reset with req=4'b1111 held, clr high 3 cycles then low → grant=0 during clr; grant=4'b0001 one cycle after clr falls; owner_id=0; rr_ptr=1.
- Single client 2, req_display=32'h1234_5678, req_en=8'hFF, blink=0, held 40 cycles → grant stays 4'b0100, no preemption, display=32'h12345678 and en=8'hFF from the cycle after grant.
- Client 0 owns, client 3 raises req → after 8 cycles of ownership, one GAP cycle (grant=0, en=0), then grant=4'b1000; with client 0 still requesting, client 0 regains grant after client 3's slice.
- Owner 1 drops req at cycle t → grant=0 and en=0 at t+1; with req=4'b0101 at t+1, grant=4'b0100 at t+2 (rr_ptr=2 beats client 0).
- req_blink=8'h0F, req_en=8'hFF → en alternates 8'hFF/8'hF0 every 4 cycles.
- clr asserted mid-OWN → all outputs return to reset values the next cycle.
